// File: rtl/va_req_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | va_req_gen_pkg : shared sizes and per-VC FSM state encodings         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package va_req_gen_pkg;
  localparam int N  = 5;
  localparam int V  = 4;
  localparam int RW = 3;
  localparam int NV = N * V;

  localparam logic [1:0] IVC_IDLE   = 2'd0;
  localparam logic [1:0] IVC_VA     = 2'd1;
  localparam logic [1:0] IVC_ACTIVE = 2'd2;
endpackage
`default_nettype wire

// File: rtl/va_req_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | va_req_gen_if : input-port side of the VC allocation request path    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface va_req_gen_if;
  import va_req_gen_pkg::*;

  logic [V-1:0]    head_valid;
  logic [V*RW-1:0] head_route;
  logic [V-1:0]    tail_sent;
  logic [NV-1:0]   ovc_free;
  logic [V-1:0]    vc_granted;
  logic [V*NV-1:0] req_vc;
  logic [V*NV-1:0] alloc_vc;
  logic [V-1:0]    alloc_valid;
  logic [NV-1:0]   ovc_claim;
  logic [NV-1:0]   ovc_release;
  logic [V-1:0]    route_err;

  modport master (
    output head_valid, head_route, tail_sent, ovc_free, vc_granted,
    input  req_vc, alloc_vc, alloc_valid, ovc_claim, ovc_release, route_err
  );

  modport slave (
    input  head_valid, head_route, tail_sent, ovc_free, vc_granted,
    output req_vc, alloc_vc, alloc_valid, ovc_claim, ovc_release, route_err
  );
endinterface
`default_nettype wire

// File: rtl/va_req_gen_ivc_va_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ivc_va_ctrl : one input VC's IDLE/VA/ACTIVE FSM, route and alloc regs|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module ivc_va_ctrl
  import va_req_gen_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          head_valid,
  input  logic [RW-1:0] head_route,
  input  logic          tail_sent,
  input  logic [NV-1:0] ovc_free,
  input  logic          vc_granted,
  output logic [NV-1:0] req,
  output logic [NV-1:0] alloc,
  output logic [NV-1:0] claim,
  output logic [NV-1:0] rel,
  output logic          alloc_valid,
  output logic          route_err
);

  function automatic logic [V-1:0] pick_lowest(input logic [V-1:0] cand_in);
    logic found;
    pick_lowest = '0;
    found       = 1'b0;
    for (int i = 0; i < V; i++) begin
      if (cand_in[i] && !found) begin
        pick_lowest[i] = 1'b1;
        found          = 1'b1;
      end
    end
  endfunction

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [RW-1:0] route_q;
  logic          route_ok;
  logic [V-1:0]  cand;
  logic          req_any;

  always_comb begin
    route_ok = (route_q < RW'(N));
    cand     = '0;
    for (int p = 0; p < N; p++) begin
      if (route_q == RW'(p)) cand = ovc_free[p*V +: V];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IVC_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IVC_IDLE:   if (head_valid)           state_nxt = IVC_VA;
      IVC_VA:     if (vc_granted && req_any) state_nxt = IVC_ACTIVE;
      IVC_ACTIVE: if (tail_sent)            state_nxt = IVC_IDLE;
      default:                              state_nxt = IVC_IDLE;
    endcase
  end

  // Request depends only on registered state and ovc_free, never on the grant.
  always_comb begin
    req = '0;
    if (rstn && state == IVC_VA && route_ok) begin
      for (int p = 0; p < N; p++) begin
        if (route_q == RW'(p)) req[p*V +: V] = pick_lowest(cand);
      end
    end
    req_any     = |req;
    claim       = vc_granted ? req : '0;
    alloc_valid = (state == IVC_ACTIVE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      route_q   <= '0;
      alloc     <= '0;
      rel       <= '0;
      route_err <= 1'b0;
    end else begin
      if (state == IVC_IDLE && head_valid) route_q <= head_route;
      if (state == IVC_VA && vc_granted && req_any) alloc <= req;
      else if (state == IVC_ACTIVE && tail_sent)    alloc <= '0;
      rel       <= (state == IVC_ACTIVE && tail_sent) ? alloc : '0;
      route_err <= route_err | (state == IVC_VA && !route_ok);
    end
  end

  a_no_spurious_grant: assert property (@(posedge clk) disable iff (!rstn)
      !(state == IVC_VA && vc_granted && !req_any))
    else $warning("ivc_va_ctrl: vc_granted without a request, ignored");

endmodule
`default_nettype wire

// File: rtl/va_req_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | va_req_gen : per-input-port VC allocation request generator          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module va_req_gen
  import va_req_gen_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  va_req_gen_if.slave  bus
);

  logic [NV-1:0] claim_v [V];
  logic [NV-1:0] rel_v   [V];

  for (genvar v = 0; v < V; v++) begin : g_ivc
    ivc_va_ctrl u_ctrl (
      .clk        (clk),
      .rstn       (rstn),
      .head_valid (bus.head_valid[v]),
      .head_route (bus.head_route[v*RW +: RW]),
      .tail_sent  (bus.tail_sent[v]),
      .ovc_free   (bus.ovc_free),
      .vc_granted (bus.vc_granted[v]),
      .req        (bus.req_vc[v*NV +: NV]),
      .alloc      (bus.alloc_vc[v*NV +: NV]),
      .claim      (claim_v[v]),
      .rel        (rel_v[v]),
      .alloc_valid(bus.alloc_valid[v]),
      .route_err  (bus.route_err[v])
    );
  end

  always_comb begin
    bus.ovc_claim   = '0;
    bus.ovc_release = '0;
    for (int v = 0; v < V; v++) begin
      bus.ovc_claim   = bus.ovc_claim   | claim_v[v];
      bus.ovc_release = bus.ovc_release | rel_v[v];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_va_req_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_va_req_gen : table + scoreboard checks of the VA request generator|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_va_req_gen;
  import va_req_gen_pkg::*;

  typedef struct {
    logic [3:0]  hv;
    logic [11:0] hr;
    logic [3:0]  ts;
    logic [19:0] free;
    logic [3:0]  gnt;
    logic [79:0] req;
    logic [19:0] claim;
    logic [3:0]  aval;
    logic [19:0] rel;
    logic [3:0]  err;
    logic [79:0] alloc;
  } vec_t;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;
  vec_t tbl [13];
  vec_t sb [$];
  vec_t e;

  va_req_gen_if bus();

  va_req_gen dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] s(input int v, input logic [19:0] x);
    logic [79:0] w;
    w = 80'(x);
    return w << (v * 20);
  endfunction

  function automatic vec_t mk(input logic [3:0] hv, input logic [11:0] hr, input logic [3:0] ts,
                              input logic [19:0] free, input logic [3:0] gnt, input logic [79:0] req,
                              input logic [19:0] claim, input logic [3:0] aval, input logic [19:0] rel,
                              input logic [3:0] err, input logic [79:0] alloc);
    vec_t r;
    r.hv = hv; r.hr = hr; r.ts = ts; r.free = free; r.gnt = gnt;
    r.req = req; r.claim = claim; r.aval = aval; r.rel = rel; r.err = err; r.alloc = alloc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] hv, input logic [11:0] hr, input logic [3:0] ts,
                       input logic [19:0] free, input logic [3:0] gnt);
    bus.head_valid = hv;
    bus.head_route = hr;
    bus.tail_sent  = ts;
    bus.ovc_free   = free;
    bus.vc_granted = gnt;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(4'h0, 12'h0, 4'h0, 20'hFFFFF, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  localparam logic [19:0] F = 20'hFFFFF;

  initial begin
    n_chk  = 0;
    n_fail = 0;

    tbl[0]  = mk(4'h0, 12'o0012, 4'h0, F,         4'h0, 80'h0,            20'h0,     4'h0, 20'h0,     4'h0, 80'h0);
    tbl[1]  = mk(4'h1, 12'o0012, 4'h0, F,         4'h0, 80'h0,            20'h0,     4'h0, 20'h0,     4'h0, 80'h0);
    tbl[2]  = mk(4'h1, 12'o0012, 4'h0, F,         4'h1, s(0, 20'h00100),  20'h00100, 4'h0, 20'h0,     4'h0, 80'h0);
    tbl[3]  = mk(4'h0, 12'o0012, 4'h0, F,         4'h0, 80'h0,            20'h0,     4'h1, 20'h0,     4'h0, s(0, 20'h00100));
    tbl[4]  = mk(4'h2, 12'o0012, 4'h0, 20'hFFFAF, 4'h0, 80'h0,            20'h0,     4'h1, 20'h0,     4'h0, s(0, 20'h00100));
    tbl[5]  = mk(4'h0, 12'o0012, 4'h0, 20'hFFFAF, 4'h0, s(1, 20'h00020),  20'h0,     4'h1, 20'h0,     4'h0, s(0, 20'h00100));
    tbl[6]  = mk(4'h0, 12'o0012, 4'h0, 20'hFFF0F, 4'h0, 80'h0,            20'h0,     4'h1, 20'h0,     4'h0, s(0, 20'h00100));
    tbl[7]  = mk(4'h0, 12'o0012, 4'h0, 20'hFFF8F, 4'h2, s(1, 20'h00080),  20'h00080, 4'h1, 20'h0,     4'h0, s(0, 20'h00100));
    tbl[8]  = mk(4'h0, 12'o0012, 4'h0, F,         4'h0, 80'h0,            20'h0,     4'h3, 20'h0,     4'h0, s(0, 20'h00100) | s(1, 20'h00080));
    tbl[9]  = mk(4'h0, 12'o0012, 4'h1, F,         4'h0, 80'h0,            20'h0,     4'h3, 20'h0,     4'h0, s(0, 20'h00100) | s(1, 20'h00080));
    tbl[10] = mk(4'h0, 12'o0012, 4'h0, F,         4'h0, 80'h0,            20'h0,     4'h2, 20'h00100, 4'h0, s(1, 20'h00080));
    tbl[11] = mk(4'h0, 12'o0012, 4'h3, F,         4'h0, 80'h0,            20'h0,     4'h2, 20'h0,     4'h0, s(1, 20'h00080));
    tbl[12] = mk(4'h0, 12'o0012, 4'h0, F,         4'h0, 80'h0,            20'h0,     4'h0, 20'h00080, 4'h0, 80'h0);

    do_reset();

    // Table: grant on VC0, free-mask driven picks on VC1, tails on both.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].hv, tbl[i].hr, tbl[i].ts, tbl[i].free, tbl[i].gnt);
      sb.push_back(tbl[i]);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d req_vc", i),      bus.req_vc,              e.req);
      chk($sformatf("row%0d ovc_claim", i),   80'(bus.ovc_claim),      80'(e.claim));
      chk($sformatf("row%0d alloc_valid", i), 80'(bus.alloc_valid),    80'(e.aval));
      chk($sformatf("row%0d ovc_release", i), 80'(bus.ovc_release),    80'(e.rel));
      chk($sformatf("row%0d route_err", i),   80'(bus.route_err),      80'(e.err));
      chk($sformatf("row%0d alloc_vc", i),    bus.alloc_vc,            e.alloc);
      step();
    end

    // Tail release and back-to-back packet on VC1 (port 3, VC0 -> bit 12).
    do_reset();
    drive(4'h2, 12'o0030, 4'h0, F, 4'h0);
    step();
    drive(4'h2, 12'o0030, 4'h0, F, 4'h2);
    #1;
    chk("t3 req", bus.req_vc, s(1, 20'h01000));
    step();
    drive(4'h2, 12'o0030, 4'h2, F, 4'h0);
    #1;
    chk("t3 aval", 80'(bus.alloc_valid), 80'h2);
    chk("t3 alloc", bus.alloc_vc, s(1, 20'h01000));
    step();
    drive(4'h2, 12'o0030, 4'h0, F, 4'h0);
    #1;
    chk("t3 release", 80'(bus.ovc_release), 80'h01000);
    chk("t3 aval off", 80'(bus.alloc_valid), 80'h0);
    chk("t3 req gap", bus.req_vc, 80'h0);
    step();
    chk("t3 release pulse", 80'(bus.ovc_release), 80'h0);
    chk("t3 req again", bus.req_vc, s(1, 20'h01000));

    // All four VCs contend for port 3; only VC2 is granted.
    do_reset();
    drive(4'hF, 12'o3333, 4'h0, F, 4'h0);
    step();
    drive(4'h0, 12'o3333, 4'h0, F, 4'h4);
    #1;
    chk("t4 req all", bus.req_vc, s(0, 20'h01000) | s(1, 20'h01000) | s(2, 20'h01000) | s(3, 20'h01000));
    chk("t4 claim", 80'(bus.ovc_claim), 80'h01000);
    step();
    drive(4'h0, 12'o3333, 4'h0, F, 4'h0);
    #1;
    chk("t4 aval", 80'(bus.alloc_valid), 80'h4);
    chk("t4 req rest", bus.req_vc, s(0, 20'h01000) | s(1, 20'h01000) | s(3, 20'h01000));

    // Out-of-range route: error flag, no request.
    do_reset();
    drive(4'h1, 12'o0006, 4'h0, F, 4'h0);
    step();
    drive(4'h0, 12'o0006, 4'h0, F, 4'h0);
    #1;
    chk("t5 req none", bus.req_vc, 80'h0);
    step();
    chk("t5 route_err", 80'(bus.route_err), 80'h1);
    chk("t5 req still none", bus.req_vc, 80'h0);
    repeat (2) step();
    chk("t5 err sticky", 80'(bus.route_err), 80'h1);
    chk("t5 aval", 80'(bus.alloc_valid), 80'h0);

    // Asynchronous reset with VC0 in VA and VC1 ACTIVE with a tail pending.
    do_reset();
    drive(4'h3, 12'o0032, 4'h0, F, 4'h0);
    step();
    drive(4'h0, 12'o0032, 4'h0, F, 4'h2);
    #1;
    chk("t6 req", bus.req_vc, s(0, 20'h00100) | s(1, 20'h01000));
    step();
    drive(4'h0, 12'o0032, 4'h2, F, 4'h0);
    #1;
    chk("t6 aval pre", 80'(bus.alloc_valid), 80'h2);
    rstn = 1'b0;
    #1;
    chk("t6 rst req", bus.req_vc, 80'h0);
    chk("t6 rst claim", 80'(bus.ovc_claim), 80'h0);
    chk("t6 rst aval", 80'(bus.alloc_valid), 80'h0);
    chk("t6 rst alloc", bus.alloc_vc, 80'h0);
    step();
    rstn = 1'b1;
    drive(4'h0, 12'o0032, 4'h0, F, 4'h0);
    #1;
    chk("t6 no release a", 80'(bus.ovc_release), 80'h0);
    step();
    chk("t6 no release b", 80'(bus.ovc_release), 80'h0);
    chk("t6 idle aval", 80'(bus.alloc_valid), 80'h0);
    chk("t6 idle req", bus.req_vc, 80'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
